instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 27 ++
 rtl/instr_fetch_fifo.sv | 51 +++++
 rtl/instr_fetch.sv | 126 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch slice: field positions, state
// encodings, reset address and entry layout of the issue buffer.
package instr_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int INSTR_W = 32;
    localparam int ENTRY_W = 2 * INSTR_W;  // {pc, instr}

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Two-entry issue buffer holding {pc, instr}; flush wins over push/pop.
module instr_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [ENTRY_W-1:0] head_data,
    output logic [1:0]         count
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic               rd_ptr;
    logic               wr_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_pop    = pop && (count != 2'd0);
    assign do_push   = push && (count != 2'(DEPTH));
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory request, a 2-entry issue buffer,
// redirect handling with stale-response dropping, and field decode of the head.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [31:0]  imem_addr,
    input  logic         imem_rsp_valid,
    input  logic [31:0]  imem_rsp_data,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         issue_valid,
    input  logic         issue_ready,
    output logic [5:0]   Opcode,
    output logic [5:0]   Funct,
    output logic [4:0]   rs,
    output logic [4:0]   rt,
    output logic [4:0]   rd,
    output logic [4:0]   shamt,
    output logic [15:0]  imm,
    output logic [31:0]  issue_pc,
    output fetch_state_t dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the producer holds its payload while valid && !ready, except that a
    // redirect may retarget a request that memory has not yet accepted.

    fetch_state_t       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic               drop_q, drop_d;
    logic               accept;
    logic               push;
    logic               pop;
    logic               flush;
    logic [1:0]         fifo_count;
    logic [ENTRY_W-1:0] head;
    logic [INSTR_W-1:0] instr;

    assign imem_req_valid = reset_n && (state_q == S_REQ) && !drop_q && (fifo_count <= 2'd1);
    assign imem_addr      = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign issue_valid    = (fifo_count != 2'd0);
    assign pop            = issue_valid && issue_ready && !redirect_valid;
    assign dbg_state      = state_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            pc_d    = align_word(redirect_pc);
            state_d = S_REQ;
            // Any request still in flight must have its response swallowed.
            drop_d  = accept || ((state_q == S_WAIT || drop_q) && !imem_rsp_valid);
        end else begin
            case (state_q)
                S_REQ: begin
                    if (drop_q && imem_rsp_valid) begin
                        drop_d = 1'b0;
                    end
                    if (accept) begin
                        state_d    = S_WAIT;
                        pc_d       = pc_q + 32'd4;
                        fetch_pc_d = pc_q;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        push    = 1'b1;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            fetch_pc_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
        end
    end

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({fetch_pc_q, imem_rsp_data}),
        .pop       (pop),
        .flush     (flush),
        .head_data (head),
        .count     (fifo_count)
    );

    // Fields read as zero whenever the buffer is empty.
    assign instr    = issue_valid ? head[INSTR_W-1:0] : '0;
    assign issue_pc = issue_valid ? head[ENTRY_W-1:INSTR_W] : '0;
    assign Opcode   = instr[OPCODE_LSB +: 6];
    assign rs       = instr[RS_LSB +: 5];
    assign rt       = instr[RT_LSB +: 5];
    assign rd       = instr[RD_LSB +: 5];
    assign shamt    = instr[SHAMT_LSB +: 5];
    assign Funct    = instr[FUNCT_LSB +: 6];
    assign imm      = instr[IMM_LSB +: 16];

endmodule
